// File: rtl/ir_stream.sv
// ---------------------------------------------------------------------------
// ir_stream : bit-serial 802.16 OFDMA block interleaver (FEC -> mapper).
//
// Each input block of Ncbps = 12*Ncpc*Nsub bits is written into one half of
// a ping-pong bit buffer at its permuted address (m_k then j_k). The
// reader drains the other half sequentially, so one block fills while the
// previous one drains.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   mod_sel    0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM (sampled at block start)
//   subch_sel  0..4 -> 1/2/4/8/16 subchannels, 5..7 illegal
//   in_bit / in_valid / in_ready     coded input stream
//   out_bit / out_valid / out_ready  interleaved output stream
//   out_last   final bit of an output block (qualified by out_valid)
//   cfg_err    configuration presented at block start is unusable
// ---------------------------------------------------------------------------
module ir_stream #(
  parameter int MAX_NCBPS = 1152,
  parameter int AW        = $clog2(MAX_NCBPS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mod_sel,
  input  logic [2:0] subch_sel,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       cfg_err
);

  localparam logic [AW-1:0] ONE = AW'(1);

  // Writer state
  logic [AW-1:0] r_k, r_q, r_m;
  logic [3:0]    r_c;
  logic [1:0]    r_c3, r_q3;     // c mod 3, q mod 3
  logic          r_wb;
  logic [AW-1:0] r_wd, r_wnm1;   // latched d and Ncbps-1 of the block being written
  logic [1:0]    r_ws;
  // Shared bank bookkeeping
  logic [1:0]    r_full;
  logic [AW-1:0] r_blast [2];    // per-bank Ncbps-1
  // Reader state
  logic          r_rb, r_obank;
  logic [AW-1:0] r_raddr;
  logic          r_out_bit, r_out_valid, r_out_last;
  // Bit buffer (no reset: contents are always overwritten before being read)
  logic          r_mem0 [MAX_NCBPS];
  logic          r_mem1 [MAX_NCBPS];

  logic [2:0]    w_ncpc;
  logic [1:0]    w_s_live;
  logic [9:0]    w_d_live;
  logic [13:0]   w_n_live;
  logic          w_k0, w_acc, w_wlast;
  logic [AW-1:0] w_d, w_nm1, w_j;
  logic [1:0]    w_s, w_ofs3;
  logic [2:0]    w_t3;
  logic          w_load, w_fetch, w_rlast, w_free, w_rbit;
  logic [1:0]    w_set, w_clr;

  // Live configuration decode; only consulted while the writer sits at k=0
  always_comb begin
    w_ncpc   = 3'd1;
    w_s_live = 2'd1;
    case (mod_sel)
      2'd0:    begin w_ncpc = 3'd1; w_s_live = 2'd1; end
      2'd1:    begin w_ncpc = 3'd2; w_s_live = 2'd1; end
      2'd2:    begin w_ncpc = 3'd4; w_s_live = 2'd2; end
      default: begin w_ncpc = 3'd6; w_s_live = 2'd3; end
    endcase
    w_d_live = 10'(w_ncpc) << subch_sel;
    w_n_live = (14'(w_d_live) << 3) + (14'(w_d_live) << 2);
  end

  assign w_k0    = (r_k == '0);
  assign cfg_err = w_k0 && ((subch_sel > 3'd4) || (w_n_live > 14'(MAX_NCBPS)));
  assign w_d     = w_k0 ? AW'(w_d_live) : r_wd;
  assign w_s     = w_k0 ? w_s_live : r_ws;
  assign w_nm1   = w_k0 ? AW'(w_n_live - 14'd1) : r_wnm1;

  assign in_ready = reset && !cfg_err && !r_full[r_wb];
  assign w_acc    = in_valid && in_ready;
  assign w_wlast  = (r_k == w_nm1);

  // Second permutation. d is a multiple of s, so m mod s == q mod s, and
  // Ncbps is a multiple of s, so it drops out of the rotation term.
  assign w_t3   = {1'b0, r_q3} + 3'd3 - {1'b0, r_c3};
  assign w_ofs3 = (w_t3 >= 3'd3) ? 2'(w_t3 - 3'd3) : w_t3[1:0];

  always_comb begin
    w_j = r_m;
    case (w_s)
      2'd2:    w_j = {r_m[AW-1:1], 1'b0} | AW'(r_m[0] ^ r_c[0]);
      2'd3:    w_j = r_m - AW'(r_q3) + AW'(w_ofs3);
      default: w_j = r_m;
    endcase
  end

  // Reader: output register refills whenever it is empty or being consumed
  assign w_load  = !r_out_valid || out_ready;
  assign w_fetch = w_load && r_full[r_rb];
  assign w_rlast = (r_raddr == r_blast[r_rb]);
  assign w_free  = r_out_valid && out_ready && r_out_last;
  assign w_rbit  = r_rb ? r_mem1[r_raddr] : r_mem0[r_raddr];

  // Writer marks a bank full and the reader frees a bank; never the same one
  assign w_set = (w_acc && w_wlast) ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_free ? (r_obank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (r_wb) r_mem1[w_j] <= in_bit;
      else      r_mem0[w_j] <= in_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k <= '0; r_q <= '0; r_m <= '0; r_c <= '0; r_c3 <= '0; r_q3 <= '0;
      r_wb <= 1'b0; r_wd <= '0; r_ws <= '0; r_wnm1 <= '0;
      r_full <= '0; r_blast[0] <= '0; r_blast[1] <= '0;
      r_rb <= 1'b0; r_obank <= 1'b0; r_raddr <= '0;
      r_out_bit <= 1'b0; r_out_valid <= 1'b0; r_out_last <= 1'b0;
    end else begin
      // Write side: m accumulates d per column, restarts at q on column wrap
      if (w_acc) begin
        if (w_k0) begin
          r_wd   <= w_d;
          r_ws   <= w_s;
          r_wnm1 <= w_nm1;
        end
        if (w_wlast) begin
          r_k <= '0; r_q <= '0; r_m <= '0; r_c <= '0; r_c3 <= '0; r_q3 <= '0;
          r_blast[r_wb] <= w_nm1;
          r_wb          <= !r_wb;
        end else begin
          r_k <= r_k + ONE;
          if (r_c == 4'd11) begin
            r_c  <= '0;
            r_c3 <= '0;
            r_q  <= r_q + ONE;
            r_m  <= r_q + ONE;
            r_q3 <= (r_q3 == 2'd2) ? 2'd0 : r_q3 + 2'd1;
          end else begin
            r_c  <= r_c + 4'd1;
            r_c3 <= (r_c3 == 2'd2) ? 2'd0 : r_c3 + 2'd1;
            r_m  <= r_m + w_d;
          end
        end
      end
      // Read side: advance to the next bank as soon as the last address is
      // fetched so the following block streams without a bubble
      if (w_fetch) begin
        r_out_bit   <= w_rbit;
        r_out_valid <= 1'b1;
        r_out_last  <= w_rlast;
        r_obank     <= r_rb;
        if (w_rlast) begin
          r_raddr <= '0;
          r_rb    <= !r_rb;
        end else begin
          r_raddr <= r_raddr + ONE;
        end
      end else if (w_load) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_ir_stream.sv
// ---------------------------------------------------------------------------
// tb_ir_stream : self-checking bench for ir_stream. Expected output bits are
// derived from the standard j_k formula with ordinary division and queued
// when a block is driven; a negedge monitor collects handshaken output bits.
// ---------------------------------------------------------------------------
module tb_ir_stream;

  logic       clk, reset;
  logic [1:0] mod_sel;
  logic [2:0] subch_sel;
  logic       in_bit, in_valid, in_ready;
  logic       out_bit, out_valid, out_ready, out_last, cfg_err;

  int         n_chk, n_fail, acc_cnt, stalls;
  logic [1:0] exp_q [$];   // {last, bit}
  logic [1:0] rx_q  [$];

  ir_stream dut (
    .clk(clk), .reset(reset), .mod_sel(mod_sel), .subch_sel(subch_sel),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Signals seen at the negedge are those captured by the next posedge
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) rx_q.push_back({out_last, out_bit});
    if (reset && in_valid && in_ready) acc_cnt++;
  end

  function automatic int jk(input int k, input int n, input int s);
    int m;
    m = (n / 12) * (k % 12) + k / 12;
    return s * (m / s) + (m + n - (12 * m) / n) % s;
  endfunction

  // one_k: -1 all zeros, -2 random, otherwise a single one at that k.
  // stop_k: stop before driving that k. chg_k: switch subch_sel there.
  task automatic send_block(input int md, input int sb, input int one_k,
                            input int stop_k, input int chg_k, input int chg_sb);
    int ncpc, n, s;
    bit ok;
    logic b [];
    logic ob [];
    ncpc = (md == 0) ? 1 : (md == 1) ? 2 : (md == 2) ? 4 : 6;
    n = 12 * ncpc * (1 << sb);
    s = (ncpc + 1) / 2;
    b = new[n];
    ob = new[n];
    for (int k = 0; k < n; k++)
      b[k] = (one_k == -2) ? ($urandom_range(0, 1) == 1) : (k == one_k);
    for (int k = 0; k < n; k++) ob[jk(k, n, s)] = b[k];
    for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), ob[j]});
    mod_sel = md[1:0];
    subch_sel = sb[2:0];
    for (int k = 0; k < n; k++) begin
      if (k == stop_k) break;
      if (k == chg_k) subch_sel = chg_sb[2:0];
      in_bit = b[k];
      in_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 5000; t++) begin
        @(negedge clk);
        if (in_ready === 1'b1) begin ok = 1; break; end
        stalls++;
      end
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout k=%0d: in_ready=%b, need 1", k, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 0;
    for (int t = 0; t < 20000; t++) begin
      if (rx_q.size() >= n) begin ok = 1; break; end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    n_chk++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL rst_out_bit: got %b need 0", out_bit); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b need 0", out_last); end
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err: got %b need 0", cfg_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b need 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid: got %b need 0", out_valid); end
  endtask

  task automatic test_qpsk();
    int onepos[4], lastpos[4];
    int nb, idx;
    logic [1:0] r, e;
    bit ok;
    foreach (onepos[i]) begin onepos[i] = -1; lastpos[i] = -1; end
    out_ready = 1'b1;
    send_block(1, 0, 1, -1, -1, 0);
    send_block(1, 0, 13, -1, -1, 0);
    wait_rx(48, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL qpsk_drain: got %0d bits need 48", rx_q.size()); end
    else begin
      nb = 0; idx = 0;
      for (int i = 0; i < 48; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL qpsk_bit[%0d]: got %b need %b", i, r, e); end
        if (nb < 4 && r[0] && onepos[nb] < 0) onepos[nb] = idx;
        if (nb < 4 && r[1]) begin lastpos[nb] = idx; nb++; idx = 0; end else idx++;
      end
      n_chk++; if (onepos[0] !== 2) begin n_fail++; $display("FAIL qpsk_k1_pos: got %0d need 2", onepos[0]); end
      n_chk++; if (onepos[1] !== 3) begin n_fail++; $display("FAIL qpsk_k13_pos: got %0d need 3", onepos[1]); end
      n_chk++; if (lastpos[0] !== 23) begin n_fail++; $display("FAIL qpsk_last: got %0d need 23", lastpos[0]); end
    end
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL qpsk_extra: got %0d bits need 0", rx_q.size()); end
  endtask

  task automatic test_16qam();
    int onepos[4], lastpos[4];
    int nb, idx;
    logic [1:0] r, e;
    bit ok;
    foreach (onepos[i]) begin onepos[i] = -1; lastpos[i] = -1; end
    out_ready = 1'b1;
    send_block(2, 0, 1, -1, -1, 0);
    send_block(2, 0, 0, -1, -1, 0);
    send_block(2, 0, -2, -1, -1, 0);
    wait_rx(144, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL qam16_drain: got %0d bits need 144", rx_q.size()); end
    else begin
      nb = 0; idx = 0;
      for (int i = 0; i < 144; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL qam16_bit[%0d]: got %b need %b", i, r, e); end
        if (nb < 4 && r[0] && onepos[nb] < 0) onepos[nb] = idx;
        if (nb < 4 && r[1]) begin lastpos[nb] = idx; nb++; idx = 0; end else idx++;
      end
      n_chk++; if (onepos[0] !== 5) begin n_fail++; $display("FAIL qam16_k1_pos: got %0d need 5", onepos[0]); end
      n_chk++; if (onepos[1] !== 0) begin n_fail++; $display("FAIL qam16_k0_pos: got %0d need 0", onepos[1]); end
      n_chk++; if (lastpos[2] !== 47) begin n_fail++; $display("FAIL qam16_last: got %0d need 47", lastpos[2]); end
    end
  endtask

  task automatic test_back_to_back();
    int onepos[4], lastpos[4];
    int nb, idx;
    logic [1:0] r, e;
    bit ok;
    foreach (onepos[i]) begin onepos[i] = -1; lastpos[i] = -1; end
    out_ready = 1'b1;
    stalls = 0;
    send_block(3, 4, -2, -1, -1, 0);
    fork
      send_block(3, 0, 1, -1, -1, 0);
      begin
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_lat_c1: out_valid=%b need 0", out_valid); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_lat_c2: out_valid=%b need 1", out_valid); end
      end
    join
    n_chk++; if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stall: got %0d stall cycles need 0", stalls); end
    wait_rx(1224, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d bits need 1224", rx_q.size()); end
    else begin
      nb = 0; idx = 0;
      for (int i = 0; i < 1224; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL b2b_bit[%0d]: got %b need %b", i, r, e); end
        if (nb < 4 && r[0] && onepos[nb] < 0) onepos[nb] = idx;
        if (nb < 4 && r[1]) begin lastpos[nb] = idx; nb++; idx = 0; end else idx++;
      end
      n_chk++; if (onepos[1] !== 8) begin n_fail++; $display("FAIL b2b_k1_pos: got %0d need 8", onepos[1]); end
      n_chk++; if (lastpos[0] !== 1151) begin n_fail++; $display("FAIL b2b_last0: got %0d need 1151", lastpos[0]); end
      n_chk++; if (lastpos[1] !== 71) begin n_fail++; $display("FAIL b2b_last1: got %0d need 71", lastpos[1]); end
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    logic [1:0] first, r, e;
    bit ok;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send_block(1, 0, -2, -1, -1, 0);
        send_block(1, 0, -2, -1, -1, 0);
        send_block(1, 0, -2, -1, -1, 0);
      end
      begin
        for (int c = 1; c <= 100; c++) begin
          @(posedge clk); #1;
          if (c >= 60 && c % 10 == 0) begin
            first = exp_q[0];
            n_chk++;
            if (out_valid !== 1'b1 || out_bit !== first[0]) begin
              n_fail++;
              $display("FAIL bp_hold c=%0d: valid,bit=%b%b need 1%b", c, out_valid, out_bit, first[0]);
            end
          end
        end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
        n_chk++; if (acc_cnt - acc0 !== 48) begin n_fail++; $display("FAIL bp_accepted: got %0d need 48", acc_cnt - acc0); end
        out_ready = 1'b1;
      end
    join
    wait_rx(72, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: got %0d bits need 72", rx_q.size()); end
    else begin
      for (int i = 0; i < 72; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL bp_bit[%0d]: got %b need %b", i, r, e); end
      end
    end
  endtask

  task automatic test_cfg_err();
    int acc0, lastpos;
    logic [1:0] r, e;
    bit ok;
    out_ready = 1'b1;
    acc0 = acc_cnt;
    mod_sel = 2'd1; subch_sel = 3'd5; in_bit = 1'b1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_set: got %b need 1", cfg_err); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_in_ready: got %b need 0", in_ready); end
    n_chk++; if (acc_cnt !== acc0) begin n_fail++; $display("FAIL cfg_accepted: got %0d need 0", acc_cnt - acc0); end
    subch_sel = 3'd1;
    #1;
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear: got %b need 0", cfg_err); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_back: got %b need 1", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    send_block(1, 1, -2, -1, 5, 3);
    wait_rx(48, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL cfg_drain: got %0d bits need 48", rx_q.size()); end
    else begin
      lastpos = -1;
      for (int i = 0; i < 48; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL cfg_bit[%0d]: got %b need %b", i, r, e); end
        if (r[1] && lastpos < 0) lastpos = i;
      end
      n_chk++; if (lastpos !== 47) begin n_fail++; $display("FAIL cfg_last: got %0d need 47", lastpos); end
    end
  endtask

  task automatic test_reset_mid();
    int n, onepos;
    logic [1:0] r, e;
    bit ok;
    out_ready = 1'b1;
    send_block(1, 0, -2, -1, -1, 0);
    send_block(1, 0, -2, 10, -1, 0);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_draining: out_valid=%b need 1", out_valid); end
    reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b need 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b need 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    n = rx_q.size();
    for (int i = 0; i < n; i++) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_chk++;
      if (r !== e) begin n_fail++; $display("FAIL rmid_pre_bit[%0d]: got %b need %b", i, r, e); end
    end
    exp_q.delete();
    repeat (40) @(posedge clk);
    #1;
    n_chk++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rmid_residual: got %0d bits need 0", rx_q.size()); end
    send_block(1, 0, 1, -1, -1, 0);
    wait_rx(24, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rmid_drain: got %0d bits need 24", rx_q.size()); end
    else begin
      onepos = -1;
      for (int i = 0; i < 24; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_chk++;
        if (r !== e) begin n_fail++; $display("FAIL rmid_bit[%0d]: got %b need %b", i, r, e); end
        if (r[0] && onepos < 0) onepos = i;
      end
      n_chk++; if (onepos !== 2) begin n_fail++; $display("FAIL rmid_pos: got %0d need 2", onepos); end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; mod_sel = 2'd0; subch_sel = 3'd0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk = 0; n_fail = 0; acc_cnt = 0; stalls = 0;
    test_reset();
    test_qpsk();
    test_16qam();
    test_back_to_back();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
